axi_sram_slave: RTL and testbench
=================================

Name: axi_sram_slave

Overview:
- Behavioural AXI slave memory that sits directly downstream of the CPU-side AXI master.
- Answers its AR/R and AW/W/B channels from an internal word-addressed SRAM array.
- Used as the simulation and FPGA bring-up backing store for instruction fetch and data accesses.
- Read and write paths are independent FSMs, each with one outstanding transaction; supports single-beat and INCR/FIXED bursts.

Parameters:
- DEPTH_LOG2, 16, number of 32-bit words = 2^DEPTH_LOG2.
- BASE_ADDR, 32'h1C00_0000, byte address of word 0.
- READ_LATENCY, 2, cycles from AR handshake to first rvalid (minimum 1).

Ports:
- aclk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- s_arid  in  4  read ID
- s_araddr  in  32  read byte address
- s_arlen  in  8  beats-1
- s_arsize  in  3  bytes/beat = 1<<size
- s_arburst  in  2  00 FIXED, 01 INCR, 10 WRAP (treated as INCR)
- s_arvalid  in  1  / s_arready  out  1
- s_rid  out  4  echoes latched arid
- s_rdata  out  32
- s_rresp  out  2  00 OKAY, 11 DECERR
- s_rlast  out  1
- s_rvalid  out  1  / s_rready  in  1
- s_awid  in  4
- s_awaddr  in  32
- s_awlen  in  8
- s_awsize  in  3
- s_awburst  in  2
- s_awvalid  in  1  / s_awready  out  1
- s_wid  in  4  ignored
- s_wdata  in  32
- s_wstrb  in  4  byte enables
- s_wlast  in  1
- s_wvalid  in  1  / s_wready  out  1
- s_bid  out  4  echoes latched awid
- s_bresp  out  2
- s_bvalid  out  1  / s_bready  in  1
- Master lock/cache/prot outputs are not consumed; they are left unconnected at the top.

Behaviour:
- Reset: aresetn low at a posedge aclk returns both FSMs to idle. All outputs reset to 0: arready, awready, wready, rvalid, rlast, bvalid, rid, rdata, rresp, bid, bresp. Memory contents are not cleared. Reset mid-burst abandons the transaction; no partial B or R is emitted afterwards.

Read FSM states: RD_IDLE, RD_WAIT, RD_DATA.
- RD_IDLE: arready=1 (registered, first high one cycle after reset release). On arvalid&&arready, latch id/addr/len/size/burst, load the latency counter with READ_LATENCY-1, drop arready, go to RD_WAIT.
- RD_WAIT: count down. At 0, present beat 0 (rvalid=1) and go to RD_DATA.
- RD_DATA: rdata/rresp/rlast are held stable while rvalid&&!rready.
  - On handshake: if beat==len, drop rvalid, go to RD_IDLE (arready high the following cycle).
  - Otherwise present the next beat on the next cycle (back-to-back beats, no bubble).
- Address step: INCR adds 1<<size and wraps modulo 2^32; FIXED holds the address.
- Word index = (addr-BASE_ADDR)>>2, with bits [1:0] ignored.
- Out of range (addr<BASE_ADDR or index>=2^DEPTH_LOG2): rresp=DECERR, rdata=0.
- rlast=1 exactly on beat len; a single-beat read (len=0) has rlast=1 on its only beat.

Write FSM states: WR_IDLE, WR_DATA, WR_RESP.
- WR_IDLE: awready=1. On handshake, latch id/addr/len/size/burst, clear the beat counter and the error flag, go to WR_DATA.
- WR_DATA: wready=1.
  - Each w handshake writes the bytes enabled by wstrb at the current address, then steps the address as for reads.
  - An out-of-range beat sets the error flag and writes nothing.
  - Beats past len+1 are accepted and discarded; they also set the error flag.
  - wlast on a handshake ends the burst: go to WR_RESP with bvalid=1, bresp=DECERR if the error flag is set, else OKAY.
  - W is only accepted after AW; wready=0 outside WR_DATA.
- WR_RESP: bvalid and bresp are held until bready, then go to WR_IDLE.

Read/write interaction:
- A write and a read beat to the same word in the same cycle: the read returns the old data; the new data is visible from the next beat.

Optional Feature:
- Macro AXI_SLAVE_RAND_STALL_EN.
- Defined: a 16-bit LFSR (seed 16'hACE1, reset on aresetn) gates arready, awready and wready, and delays rvalid/bvalid assertion by 0-3 cycles.
  - Once asserted, a valid is never withdrawn before its handshake.
  - Ready may only deassert when no handshake is occurring in that cycle.
- Undefined: timing is exactly as stated in Behaviour (deterministic).

Test Plan:
- Reset then single read: preload word 0 = 32'hDEAD_BEEF, AR addr 32'h1C00_0000 len 0 id 3 -> rvalid exactly READ_LATENCY cycles after AR handshake, rdata 32'hDEAD_BEEF, rid 3, rlast 1, rresp 00.
- Strobed write then read: AW 32'h1C00_0010, W 32'h1122_3344 strb 4'b0101 over old 32'hFFFF_FFFF -> bresp 00, bid = awid; reading back gives 32'hFF22_FF44.
- INCR burst read len 3 from 32'h1C00_0020 with rready low on beat 1 for 2 cycles -> 4 beats from consecutive words, beat 1 held stable, rlast only on beat 3.
- Out of range: AR addr 32'h0000_0000 -> rresp 11, rdata 0. AW 32'h1C00_0000+(4<<DEPTH_LOG2) -> bresp 11, memory unchanged.
- Reset mid-burst: aresetn low during beat 2 of a len 7 read -> next cycle rvalid 0. After release, a new AR is accepted with arready high one cycle later.
- bready held low 5 cycles -> bvalid/bresp stable throughout. awready stays 0 until the B handshake completes.

Source files
------------

// File: rtl/axi_sram_slave.sv
// AXI slave memory: word-addressed SRAM behind independent read/write FSMs.
// Optional macro AXI_SLAVE_RAND_STALL_EN adds LFSR-driven ready/valid stalls.
module axi_sram_slave #(
   parameter int unsigned DEPTH_LOG2   = 16,
   parameter logic [31:0] BASE_ADDR    = 32'h1C00_0000,
   parameter int unsigned READ_LATENCY = 2
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic [3:0]  s_arid,
   input  logic [31:0] s_araddr,
   input  logic [7:0]  s_arlen,
   input  logic [2:0]  s_arsize,
   input  logic [1:0]  s_arburst,
   input  logic        s_arvalid,
   output logic        s_arready,
   output logic [3:0]  s_rid,
   output logic [31:0] s_rdata,
   output logic [1:0]  s_rresp,
   output logic        s_rlast,
   output logic        s_rvalid,
   input  logic        s_rready,
   input  logic [3:0]  s_awid,
   input  logic [31:0] s_awaddr,
   input  logic [7:0]  s_awlen,
   input  logic [2:0]  s_awsize,
   input  logic [1:0]  s_awburst,
   input  logic        s_awvalid,
   output logic        s_awready,
   input  logic [3:0]  s_wid,
   input  logic [31:0] s_wdata,
   input  logic [3:0]  s_wstrb,
   input  logic        s_wlast,
   input  logic        s_wvalid,
   output logic        s_wready,
   output logic [3:0]  s_bid,
   output logic [1:0]  s_bresp,
   output logic        s_bvalid,
   input  logic        s_bready
);
   localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
   localparam logic [1:0] OKAY = 2'b00;
   localparam logic [1:0] DECERR = 2'b11;

   typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_DATA} rd_state_t;
   typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_t;

   logic [31:0] mem [DEPTH];

   function automatic logic in_range(input logic [31:0] a);
      return (a >= BASE_ADDR) && (((a - BASE_ADDR) >> 2) < DEPTH);
   endfunction

   function automatic logic [DEPTH_LOG2-1:0] word_idx(input logic [31:0] a);
      return DEPTH_LOG2'((a - BASE_ADDR) >> 2);
   endfunction

   // WRAP is treated as INCR; only FIXED holds the address
   function automatic logic [31:0] next_addr(input logic [31:0] a,
                                             input logic [2:0]  size,
                                             input logic [1:0]  burst);
      return (burst == 2'b00) ? a : a + (32'd1 << size);
   endfunction

   logic       stall_ok;
   logic [1:0] stall_dly;

`ifdef AXI_SLAVE_RAND_STALL_EN
   logic [15:0] lfsr;
   always_ff @(posedge aclk) begin
      if (!aresetn) lfsr <= 16'hACE1;
      else lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   end
   assign stall_ok  = lfsr[0] | lfsr[3];
   assign stall_dly = lfsr[6:5];
`else
   assign stall_ok  = 1'b1;
   assign stall_dly = 2'd0;
`endif

   logic unused;
   assign unused = ^s_wid;

   rd_state_t   rd_state;
   logic [31:0] ar_addr;
   logic [7:0]  ar_len;
   logic [2:0]  ar_size;
   logic [1:0]  ar_burst;
   logic [7:0]  rd_beat;
   logic [7:0]  rd_cnt;
   logic [1:0]  rd_dly;
   logic [31:0] rd_nxt;
   logic [31:0] rd_src;
   logic        rd_ok;
   logic [31:0] rd_word;

   always_comb begin
      rd_nxt  = next_addr(ar_addr, ar_size, ar_burst);
      rd_src  = (rd_state == RD_DATA) ? rd_nxt : ar_addr;
      rd_ok   = in_range(rd_src);
      rd_word = rd_ok ? mem[word_idx(rd_src)] : 32'd0;
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         rd_state  <= RD_IDLE;
         s_arready <= 1'b0;
         s_rvalid  <= 1'b0;
         s_rlast   <= 1'b0;
         s_rid     <= '0;
         s_rdata   <= '0;
         s_rresp   <= OKAY;
         ar_addr   <= '0;
         ar_len    <= '0;
         ar_size   <= '0;
         ar_burst  <= '0;
         rd_beat   <= '0;
         rd_cnt    <= '0;
         rd_dly    <= '0;
      end else begin
         unique case (rd_state)
            RD_IDLE: begin
               if (s_arvalid && s_arready) begin
                  s_arready <= 1'b0;
                  s_rid     <= s_arid;
                  ar_addr   <= s_araddr;
                  ar_len    <= s_arlen;
                  ar_size   <= s_arsize;
                  ar_burst  <= s_arburst;
                  rd_beat   <= '0;
                  rd_cnt    <= 8'(READ_LATENCY - 1);
                  rd_dly    <= stall_dly;
                  rd_state  <= RD_WAIT;
               end else begin
                  s_arready <= stall_ok;
               end
            end
            RD_WAIT: begin
               if (rd_cnt != 8'd0) begin
                  rd_cnt <= rd_cnt - 8'd1;
               end else if (rd_dly != 2'd0) begin
                  rd_dly <= rd_dly - 2'd1;
               end else begin
                  s_rvalid <= 1'b1;
                  s_rdata  <= rd_word;
                  s_rresp  <= rd_ok ? OKAY : DECERR;
                  s_rlast  <= (ar_len == 8'd0);
                  rd_state <= RD_DATA;
               end
            end
            RD_DATA: begin
               // rvalid is always high here; beats stay put until rready
               if (s_rready) begin
                  if (rd_beat == ar_len) begin
                     s_rvalid  <= 1'b0;
                     s_rlast   <= 1'b0;
                     s_arready <= 1'b1;
                     rd_state  <= RD_IDLE;
                  end else begin
                     ar_addr <= rd_nxt;
                     rd_beat <= rd_beat + 8'd1;
                     s_rdata <= rd_word;
                     s_rresp <= rd_ok ? OKAY : DECERR;
                     s_rlast <= (rd_beat + 8'd1 == ar_len);
                  end
               end
            end
            default: rd_state <= RD_IDLE;
         endcase
      end
   end

   wr_state_t   wr_state;
   logic [31:0] aw_addr;
   logic [7:0]  aw_len;
   logic [2:0]  aw_size;
   logic [1:0]  aw_burst;
   logic [8:0]  wr_beat;
   logic        wr_err;
   logic [1:0]  wr_dly;
   logic        w_hs;
   logic        w_ok;
   logic        mem_we;

   always_comb begin
      w_hs   = s_wvalid && s_wready;
      w_ok   = in_range(aw_addr) && ({1'b0, aw_len} >= wr_beat);
      mem_we = aresetn && w_hs && w_ok;
   end

   always_ff @(posedge aclk) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (s_wstrb[b]) mem[word_idx(aw_addr)][8*b +: 8] <= s_wdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         wr_state  <= WR_IDLE;
         s_awready <= 1'b0;
         s_wready  <= 1'b0;
         s_bvalid  <= 1'b0;
         s_bid     <= '0;
         s_bresp   <= OKAY;
         aw_addr   <= '0;
         aw_len    <= '0;
         aw_size   <= '0;
         aw_burst  <= '0;
         wr_beat   <= '0;
         wr_err    <= 1'b0;
         wr_dly    <= '0;
      end else begin
         unique case (wr_state)
            WR_IDLE: begin
               if (s_awvalid && s_awready) begin
                  s_awready <= 1'b0;
                  s_wready  <= stall_ok;
                  s_bid     <= s_awid;
                  aw_addr   <= s_awaddr;
                  aw_len    <= s_awlen;
                  aw_size   <= s_awsize;
                  aw_burst  <= s_awburst;
                  wr_beat   <= '0;
                  wr_err    <= 1'b0;
                  wr_state  <= WR_DATA;
               end else begin
                  s_awready <= stall_ok;
               end
            end
            WR_DATA: begin
               if (w_hs) begin
                  aw_addr <= next_addr(aw_addr, aw_size, aw_burst);
                  if (wr_beat != 9'h1FF) wr_beat <= wr_beat + 9'd1;
                  if (!w_ok) wr_err <= 1'b1;
                  if (s_wlast) begin
                     s_wready <= 1'b0;
                     s_bresp  <= (wr_err || !w_ok) ? DECERR : OKAY;
                     s_bvalid <= (stall_dly == 2'd0);
                     wr_dly   <= stall_dly;
                     wr_state <= WR_RESP;
                  end
               end else begin
                  s_wready <= stall_ok;
               end
            end
            WR_RESP: begin
               if (!s_bvalid) begin
                  if (wr_dly <= 2'd1) s_bvalid <= 1'b1;
                  wr_dly <= wr_dly - 2'd1;
               end else if (s_bready) begin
                  s_bvalid  <= 1'b0;
                  s_awready <= 1'b1;
                  wr_state  <= WR_IDLE;
               end
            end
            default: wr_state <= WR_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: expected R/B responses are queued
// by the stimulus and popped by a negedge monitor on each handshake.
module tb_axi_sram_slave;
   localparam logic [31:0] BASE = 32'h1C00_0000;
   localparam int RL  = 2;
   localparam int LIM = 100;
   localparam logic [1:0] INCR = 2'b01;
   localparam logic [1:0] FIXD = 2'b00;

   logic        aclk, aresetn;
   logic [3:0]  s_arid, s_rid, s_awid, s_wid, s_bid, s_wstrb;
   logic [31:0] s_araddr, s_rdata, s_awaddr, s_wdata;
   logic [7:0]  s_arlen, s_awlen;
   logic [2:0]  s_arsize, s_awsize;
   logic [1:0]  s_arburst, s_awburst, s_rresp, s_bresp;
   logic        s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;
   logic        s_awvalid, s_awready, s_wlast, s_wvalid, s_wready;
   logic        s_bvalid, s_bready;

   axi_sram_slave dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen),
      .s_arsize(s_arsize), .s_arburst(s_arburst),
      .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp),
      .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
      .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
      .s_awsize(s_awsize), .s_awburst(s_awburst),
      .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wid(s_wid), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
      .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid),
      .s_bready(s_bready)
   );

   typedef struct packed {
      logic [3:0]  id;
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
   } rexp_t;
   typedef struct packed {
      logic [3:0] id;
      logic [1:0] resp;
   } bexp_t;

   rexp_t rq[$];
   bexp_t bq[$];
   int checks = 0;
   int errors = 0;

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   always @(negedge aclk) begin
      rexp_t re;
      bexp_t be;
      if (s_rvalid && s_rready) begin
         checks++;
         if (rq.size() == 0) begin
            errors++;
            $display("FAIL r_unexpected got data=%h want no beat", s_rdata);
         end else begin
            re = rq.pop_front();
            if ({s_rid, s_rdata, s_rresp, s_rlast} !== re) begin
               errors++;
               $display("FAIL r_beat got id=%0h data=%h resp=%0d last=%0b want id=%0h data=%h resp=%0d last=%0b",
                        s_rid, s_rdata, s_rresp, s_rlast, re.id, re.data, re.resp, re.last);
            end
         end
      end
      if (s_bvalid && s_bready) begin
         checks++;
         if (bq.size() == 0) begin
            errors++;
            $display("FAIL b_unexpected got bid=%0h want no response", s_bid);
         end else begin
            be = bq.pop_front();
            if ({s_bid, s_bresp} !== be) begin
               errors++;
               $display("FAIL b_resp got id=%0h resp=%0d want id=%0h resp=%0d",
                        s_bid, s_bresp, be.id, be.resp);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
   endtask

   task automatic tmo(input string nm);
      checks++;
      errors++;
      $display("FAIL %s timeout got none want handshake", nm);
   endtask

   task automatic pushr(input logic [3:0] id, input logic [31:0] d,
                        input logic [1:0] rs, input logic l);
      rq.push_back({id, d, rs, l});
   endtask

   task automatic ar(input logic [31:0] a, input logic [7:0] len,
                     input logic [1:0] bu, input logic [3:0] id);
      int n = 0;
      s_araddr = a; s_arlen = len; s_arsize = 3'd2;
      s_arburst = bu; s_arid = id; s_arvalid = 1'b1;
      do begin @(negedge aclk); n++; end while (!s_arready && n < LIM);
      if (!s_arready) tmo("ar");
      @(posedge aclk); #1;
      s_arvalid = 1'b0;
   endtask

   task automatic aw(input logic [31:0] a, input logic [7:0] len,
                     input logic [3:0] id);
      int n = 0;
      s_awaddr = a; s_awlen = len; s_awsize = 3'd2;
      s_awburst = INCR; s_awid = id; s_awvalid = 1'b1;
      do begin @(negedge aclk); n++; end while (!s_awready && n < LIM);
      if (!s_awready) tmo("aw");
      @(posedge aclk); #1;
      s_awvalid = 1'b0;
   endtask

   task automatic w(input logic [31:0] d, input logic [3:0] st, input logic l);
      int n = 0;
      s_wdata = d; s_wstrb = st; s_wlast = l; s_wvalid = 1'b1;
      do begin @(negedge aclk); n++; end while (!s_wready && n < LIM);
      if (!s_wready) tmo("w");
      @(posedge aclk); #1;
      s_wvalid = 1'b0; s_wlast = 1'b0;
   endtask

   task automatic wait_r();
      int n = 0;
      while (rq.size() != 0 && n < LIM) begin @(posedge aclk); n++; end
      #1;
      if (rq.size() != 0) begin tmo("r_drain"); rq.delete(); end
   endtask

   task automatic wait_b();
      int n = 0;
      while (bq.size() != 0 && n < LIM) begin @(posedge aclk); n++; end
      #1;
      if (bq.size() != 0) begin tmo("b_drain"); bq.delete(); end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] st, input logic [3:0] id,
                     input logic [1:0] rs);
      bq.push_back({id, rs});
      aw(a, 8'd0, id);
      w(d, st, 1'b1);
      wait_b();
   endtask

   task automatic rd1(input logic [31:0] a, input logic [3:0] id,
                      input logic [31:0] d, input logic [1:0] rs);
      pushr(id, d, rs, 1'b1);
      ar(a, 8'd0, INCR, id);
      wait_r();
   endtask

   initial begin
      int n;
      int k;
      aresetn = 1'b0;
      s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0;
      s_arburst = '0; s_arvalid = 1'b0; s_rready = 1'b1;
      s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = '0;
      s_awburst = '0; s_awvalid = 1'b0; s_wid = '0; s_wdata = '0;
      s_wstrb = '0; s_wlast = 1'b0; s_wvalid = 1'b0; s_bready = 1'b1;
      repeat (3) @(posedge aclk);
      #1;
      @(negedge aclk);
      chk("reset_outs", 64'({s_arready, s_awready, s_wready, s_rvalid, s_rlast,
                             s_bvalid, s_rid, s_rdata, s_rresp, s_bid, s_bresp}), 64'd0);
      @(posedge aclk); #1;
      aresetn = 1'b1;
      @(negedge aclk);
      chk("arready_at_release", 64'(s_arready), 64'd0);
      @(negedge aclk);
      chk("arready_after_release", 64'(s_arready), 64'd1);
      chk("awready_after_release", 64'(s_awready), 64'd1);
      @(posedge aclk); #1;

      // single read with latency measurement
      wr(BASE, 32'hDEAD_BEEF, 4'hF, 4'd1, 2'b00);
      pushr(4'd3, 32'hDEAD_BEEF, 2'b00, 1'b1);
      ar(BASE, 8'd0, INCR, 4'd3);
      n = 0;
      do begin @(negedge aclk); n++; end while (!s_rvalid && n < LIM);
      chk("rd_latency", 64'(n - 1), 64'(RL));
      wait_r();

      // strobed write
      wr(BASE + 32'h10, 32'hFFFF_FFFF, 4'hF, 4'd2, 2'b00);
      wr(BASE + 32'h10, 32'h1122_3344, 4'b0101, 4'd5, 2'b00);
      rd1(BASE + 32'h10, 4'd6, 32'hFF22_FF44, 2'b00);

      // INCR burst with rready stall on beat 1
      for (int i = 0; i < 8; i++)
         wr(BASE + 32'h20 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF, 4'd2, 2'b00);
      for (int i = 0; i < 4; i++)
         pushr(4'd1, 32'hA000_0000 + 32'(i), 2'b00, i == 3);
      ar(BASE + 32'h20, 8'd3, INCR, 4'd1);
      n = 0;
      do begin @(negedge aclk); n++; end while (!(s_rvalid && s_rready) && n < LIM);
      @(posedge aclk); #1;
      s_rready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge aclk);
         chk("hold_valid", 64'(s_rvalid), 64'd1);
         chk("hold_data", 64'(s_rdata), 64'hA000_0001);
         chk("hold_last", 64'(s_rlast), 64'd0);
      end
      @(posedge aclk); #1;
      s_rready = 1'b1;
      wait_r();

      // FIXED burst keeps the address
      pushr(4'd7, 32'hA000_0002, 2'b00, 1'b0);
      pushr(4'd7, 32'hA000_0002, 2'b00, 1'b1);
      ar(BASE + 32'h28, 8'd1, FIXD, 4'd7);
      wait_r();

      // out of range and last word
      rd1(32'h0000_0000, 4'd0, 32'd0, 2'b11);
      wr(BASE + (32'd4 << 16), 32'h1234_5678, 4'hF, 4'd6, 2'b11);
      rd1(BASE, 4'd8, 32'hDEAD_BEEF, 2'b00);
      wr(BASE + 32'h3FFFC, 32'hCAFE_F00D, 4'hF, 4'd7, 2'b00);
      rd1(BASE + 32'h3FFFC, 4'd9, 32'hCAFE_F00D, 2'b00);

      // 2-beat write burst
      bq.push_back({4'd8, 2'b00});
      aw(BASE + 32'h40, 8'd1, 4'd8);
      w(32'h1111_1111, 4'hF, 1'b0);
      w(32'h2222_2222, 4'hF, 1'b1);
      wait_b();
      pushr(4'd2, 32'h1111_1111, 2'b00, 1'b0);
      pushr(4'd2, 32'h2222_2222, 2'b00, 1'b1);
      ar(BASE + 32'h40, 8'd1, INCR, 4'd2);
      wait_r();

      // surplus beat flags DECERR but the in-range beat lands
      bq.push_back({4'd10, 2'b11});
      aw(BASE + 32'h48, 8'd0, 4'd10);
      w(32'h3333_3333, 4'hF, 1'b0);
      w(32'h4444_4444, 4'hF, 1'b1);
      wait_b();
      rd1(BASE + 32'h48, 4'd11, 32'h3333_3333, 2'b00);

      // bready held low
      s_bready = 1'b0;
      bq.push_back({4'd9, 2'b00});
      aw(BASE + 32'h14, 8'd0, 4'd9);
      w(32'h5555_AAAA, 4'hF, 1'b1);
      n = 0;
      do begin @(negedge aclk); n++; end while (!s_bvalid && n < LIM);
      for (int i = 0; i < 5; i++) begin
         @(negedge aclk);
         chk("bhold_valid", 64'(s_bvalid), 64'd1);
         chk("bhold_resp_id", 64'({s_bid, s_bresp}), 64'({4'd9, 2'b00}));
         chk("bhold_awready", 64'(s_awready), 64'd0);
      end
      @(posedge aclk); #1;
      s_bready = 1'b1;
      wait_b();
      @(negedge aclk);
      chk("awready_after_b", 64'(s_awready), 64'd1);
      @(posedge aclk); #1;
      rd1(BASE + 32'h14, 4'd12, 32'h5555_AAAA, 2'b00);

      // reset during beat 2 of an 8-beat read
      for (int i = 0; i < 8; i++)
         pushr(4'd4, 32'hA000_0000 + 32'(i), 2'b00, i == 7);
      ar(BASE + 32'h20, 8'd7, INCR, 4'd4);
      n = 0;
      k = 0;
      while (k < 2 && n < LIM) begin
         @(negedge aclk);
         n++;
         if (s_rvalid && s_rready) k++;
      end
      @(posedge aclk); #1;
      s_rready = 1'b0;
      aresetn = 1'b0;
      @(posedge aclk); #1;
      @(negedge aclk);
      chk("rst_rvalid", 64'(s_rvalid), 64'd0);
      chk("rst_rdata", 64'({s_rlast, s_rdata}), 64'd0);
      chk("rst_beats_seen", 64'(rq.size()), 64'd6);
      rq.delete();
      @(posedge aclk); #1;
      aresetn = 1'b1;
      s_rready = 1'b1;
      @(negedge aclk);
      chk("rst_arready_lo", 64'(s_arready), 64'd0);
      @(negedge aclk);
      chk("rst_arready_hi", 64'(s_arready), 64'd1);
      @(posedge aclk); #1;
      rd1(BASE, 4'd13, 32'hDEAD_BEEF, 2'b00);

      repeat (4) @(posedge aclk);
      chk("rq_drained", 64'(rq.size()), 64'd0);
      chk("bq_drained", 64'(bq.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got no finish want finish");
      $fatal(1, "watchdog");
   end
endmodule
